// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver.
// Each entry holds {err, data}. Overflowing writes are dropped and reported
// through a sticky flag. A write that arrives while full is still accepted
// when the head is popped in the same cycle.
module uart_rx_fifo #(
    parameter  int DATA_W = 8,
    parameter  int ERR_W  = 3,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ERR_W-1:0]  i_wr_err,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ERR_W-1:0]  o_rd_err,
    input  logic              i_rd_ready,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    localparam int ENTRY_W = ERR_W + DATA_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    // Status decode from the registered count, plus gated head presentation.
    always_comb begin
        o_count    = count_q;
        o_full     = (count_q == CNT_FULL);
        o_empty    = (count_q == '0);
        o_rd_valid = !o_empty;
        o_overflow = overflow_q;
        head       = mem_q[rd_ptr_q];
        o_rd_data  = o_rd_valid ? head[DATA_W-1:0] : '0;
        o_rd_err   = o_rd_valid ? head[ENTRY_W-1:DATA_W] : '0;
    end

    // Handshake decode and next-state for pointers, count and overflow flag.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // can leave a signal unassigned and infer a latch.
        pop        = o_rd_valid && i_rd_ready;
        push       = i_wr_valid && (!o_full || pop);
        drop       = i_wr_valid && o_full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear request keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; writes are blocked while reset is asserted.
    always_ff @(posedge i_Clk) begin
        // NOTE: the array is deliberately not reset; stale entries are never
        // visible because the read side is gated by the count.
        if (!i_Reset && push) begin
            mem_q[wr_ptr_q] <= {i_wr_err, i_wr_data};
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios followed by randomized traffic, every
// cycle compared against a queue-based reference model of the buffer.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int ERR_W  = 3;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_Clk;
    logic              i_Reset;
    logic              i_wr_valid;
    logic [DATA_W-1:0] i_wr_data;
    logic [ERR_W-1:0]  i_wr_err;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic [ERR_W-1:0]  o_rd_err;
    logic              i_rd_ready;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;
    logic              i_clr_overflow;

    uart_rx_fifo #(.DATA_W(DATA_W), .ERR_W(ERR_W), .DEPTH(DEPTH)) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_wr_valid     (i_wr_valid),
        .i_wr_data      (i_wr_data),
        .i_wr_err       (i_wr_err),
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .o_rd_err       (o_rd_err),
        .i_rd_ready     (i_rd_ready),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Reference model: a queue of {err, data} entries and a sticky flag.
    logic [ERR_W+DATA_W-1:0] model_q [$];
    logic                    model_ovf;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules of the buffer to one clock edge.
    task automatic model_edge(input logic wv, input logic [DATA_W-1:0] wd,
                              input logic [ERR_W-1:0] we, input logic rr,
                              input logic clr, input logic rst);
        bit was_full;
        bit do_pop;
        bit do_push;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            was_full = (model_q.size() == DEPTH);
            do_pop   = (model_q.size() > 0) && rr;
            do_push  = wv && (!was_full || do_pop);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({we, wd});
            if (wv && was_full && !do_pop) model_ovf = 1'b1;
            else if (clr) model_ovf = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [ERR_W+DATA_W-1:0] head;
        int n;
        n    = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        check("count",    32'(o_count),    32'(n));
        check("empty",    32'(o_empty),    32'(n == 0));
        check("full",     32'(o_full),     32'(n == DEPTH));
        check("rd_valid", 32'(o_rd_valid), 32'(n > 0));
        check("rd_data",  32'(o_rd_data),  32'(head[DATA_W-1:0]));
        check("rd_err",   32'(o_rd_err),   32'(head[ERR_W+DATA_W-1:DATA_W]));
        check("overflow", 32'(o_overflow), 32'(model_ovf));
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare.
    task automatic cycle(input logic wv, input logic [DATA_W-1:0] wd,
                         input logic [ERR_W-1:0] we, input logic rr,
                         input logic clr, input logic rst);
        i_wr_valid     = wv;
        i_wr_data      = wd;
        i_wr_err       = we;
        i_rd_ready     = rr;
        i_clr_overflow = clr;
        i_Reset        = rst;
        @(posedge i_Clk);
        model_edge(wv, wd, we, rr, clr, rst);
        #1;
        check_outputs();
    endtask

    task automatic reset_cycle();
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic write(input logic [DATA_W-1:0] d, input logic [ERR_W-1:0] e);
        cycle(1'b1, d, e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int max_cnt;
        i_Reset        = 1'b1;
        i_wr_valid     = 1'b0;
        i_wr_data      = '0;
        i_wr_err       = '0;
        i_rd_ready     = 1'b0;
        i_clr_overflow = 1'b0;
        model_ovf      = 1'b0;

        // Reset state.
        reset_cycle();
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_data",  32'(o_rd_data), 32'd0);

        // Three writes, one with an error code, then drain in order.
        write(8'h41, 3'd0);
        write(8'h42, 3'd0);
        write(8'h43, 3'd5);
        check("t1_count", 32'(o_count), 32'd3);
        check("t1_head0", 32'(o_rd_data), 32'h41);
        pop_one();
        check("t1_head1", 32'(o_rd_data), 32'h42);
        pop_one();
        check("t1_head2", 32'(o_rd_data), 32'h43);
        check("t1_err2",  32'(o_rd_err),  32'd5);
        pop_one();
        check("t1_empty", 32'(o_empty), 32'd1);
        check("t1_zero",  32'(o_rd_data), 32'd0);
        pop_one();
        check("t1_no_underflow", 32'(o_count), 32'd0);

        // Fill to DEPTH, drop a 17th write, drain.
        for (int i = 0; i < DEPTH; i++) write(8'(i), 3'd0);
        check("t2_full",  32'(o_full),  32'd1);
        check("t2_count", 32'(o_count), 32'(DEPTH));
        write(8'hAA, 3'd0);
        check("t2_ovf",       32'(o_overflow), 32'd1);
        check("t2_count_ovf", 32'(o_count),    32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_drain", 32'(o_rd_data), 32'(i));
            pop_one();
        end
        check("t2_empty", 32'(o_empty), 32'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) write(8'(i), 3'd0);
        cycle(1'b1, 8'h55, 3'd0, 1'b1, 1'b0, 1'b0);
        check("t3_count", 32'(o_count),    32'(DEPTH));
        check("t3_ovf",   32'(o_overflow), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            check("t3_drain", 32'(o_rd_data), 32'(i));
            pop_one();
        end
        check("t3_last", 32'(o_rd_data), 32'h55);
        pop_one();

        // Streaming across pointer wrap.
        max_cnt = 0;
        write(8'h00, 3'd0);
        for (int i = 1; i < 3 * DEPTH; i++) begin
            check("t4_stream", 32'(o_rd_data), 32'(i - 1));
            cycle(1'b1, 8'(i), 3'(i), 1'b1, 1'b0, 1'b0);
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
        end
        check("t4_last", 32'(o_rd_data), 32'(3 * DEPTH - 1));
        pop_one();
        check("t4_max_count", 32'(max_cnt), 32'd1);

        // Overflow clear, then set-wins when drop and clear coincide.
        for (int i = 0; i < DEPTH; i++) write(8'(i + 8'h80), 3'd1);
        write(8'hEE, 3'd0);
        check("t5_set", 32'(o_overflow), 32'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        check("t5_clr", 32'(o_overflow), 32'd0);
        cycle(1'b1, 8'hEF, 3'd0, 1'b0, 1'b1, 1'b0);
        check("t5_set_wins", 32'(o_overflow), 32'd1);

        // Reset in the middle of a write burst.
        reset_cycle();
        for (int i = 0; i < 5; i++) write(8'(i + 8'h10), 3'd0);
        cycle(1'b1, 8'h15, 3'd0, 1'b0, 1'b0, 1'b1);
        check("t6_count", 32'(o_count),    32'd0);
        check("t6_empty", 32'(o_empty),    32'd1);
        check("t6_valid", 32'(o_rd_valid), 32'd0);
        check("t6_ovf",   32'(o_overflow), 32'd0);
        write(8'h7E, 3'd0);
        check("t6_first", 32'(o_rd_data), 32'h7E);

        // Randomized traffic with varying read pressure.
        for (int seg = 0; seg < 8; seg++) begin
            int rd_pct;
            rd_pct = (seg % 4) * 30;
            for (int i = 0; i < 250; i++) begin
                cycle(1'($urandom_range(99) < 60),
                      8'($urandom),
                      3'($urandom),
                      1'($urandom_range(99) < rd_pct),
                      1'($urandom_range(99) < 5),
                      1'($urandom_range(499) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
